// File: rtl/amba_axi4_pkg.sv
// amba_axi4_pkg: shared AXI4 response codes, register-slave FSM states and address-decode helpers.
package amba_axi4_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } responses_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  function automatic int lsb_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction
  function automatic int idx_bits(input int num_regs);
    return $clog2(num_regs);
  endfunction
endpackage

// File: rtl/amba_axi4_lite_regfile.sv
// amba_axi4_lite_regfile: NUM_REGS x DATA_WIDTH flop bank, one byte-strobed write port, one combinational read port.
module amba_axi4_lite_regfile
  import amba_axi4_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDRESS_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic [ADDRESS_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      w_oor,
  output logic                      r_oor
);
  localparam int LSB = lsb_bits(DATA_WIDTH);
  localparam int IW  = idx_bits(NUM_REGS);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IW-1:0] widx, ridx;
  logic unused_lsb;
  assign widx  = waddr[LSB +: IW];
  assign ridx  = raddr[LSB +: IW];
  // any set bit above the index field means idx >= NUM_REGS
  assign w_oor = |waddr[ADDRESS_WIDTH-1:LSB+IW];
  assign r_oor = |raddr[ADDRESS_WIDTH-1:LSB+IW];
  assign rdata = regs[ridx];
  assign unused_lsb = ^{waddr[LSB-1:0], raddr[LSB-1:0]};
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (we && widx == IW'(i)) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++)
          if (wstrb[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/amba_axi4_lite_register_slave.sv
// amba_axi4_lite_register_slave: AXI4-Lite subordinate exposing NUM_REGS byte-strobed registers.
// Define AXI4_LITE_DECERR_EN to answer out-of-range accesses with DECERR instead of wrapping the index.
module amba_axi4_lite_register_slave
  import amba_axi4_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDRESS_WIDTH-1:0]  AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      BVALID,
  input  logic                      BREADY,
  output responses_t                BRESP,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  input  logic [ADDRESS_WIDTH-1:0]  ARADDR,
  input  logic [2:0]                ARPROT,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output responses_t                RRESP
);
  localparam int SW = DATA_WIDTH / 8;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live, aw_hs, w_hs, ar_hs, w_done, we, w_oor, r_oor;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, w_addr;
  logic [DATA_WIDTH-1:0] w_data_q, w_data, rf_rdata, r_data;
  logic [SW-1:0] w_strb_q, w_strb;
  responses_t w_resp, r_resp;
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};
  assign AWREADY = live & (w_state == W_IDLE || w_state == W_HAVE_W);
  assign WREADY  = live & (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign ARREADY = live & (r_state == R_IDLE);
  assign BVALID  = w_state == W_RESP;
  assign RVALID  = r_state == R_RESP;
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign ar_hs   = ARVALID & ARREADY;
  // a half that arrived earlier comes from its latch, the completing half straight from the bus
  assign w_addr  = w_state == W_HAVE_AW ? aw_addr_q : AWADDR;
  assign w_data  = w_state == W_HAVE_W ? w_data_q : WDATA;
  assign w_strb  = w_state == W_HAVE_W ? w_strb_q : WSTRB;
`ifdef AXI4_LITE_DECERR_EN
  assign we     = w_done & ~w_oor;
  assign w_resp = w_oor ? DECERR : OKAY;
  assign r_resp = r_oor ? DECERR : OKAY;
  assign r_data = r_oor ? '0 : rf_rdata;
`else
  logic unused_oor;
  assign unused_oor = w_oor ^ r_oor;
  assign we     = w_done;
  assign w_resp = OKAY;
  assign r_resp = OKAY;
  assign r_data = rf_rdata;
`endif
  amba_axi4_lite_regfile #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk(ACLK),
    .rst_n(ARESETn),
    .we(we),
    .waddr(w_addr),
    .wdata(w_data),
    .wstrb(w_strb),
    .raddr(ARADDR),
    .rdata(rf_rdata),
    .w_oor(w_oor),
    .r_oor(r_oor)
  );
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      live    <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      live    <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  always_comb begin
    w_next = w_state;
    w_done = 1'b0;
    case (w_state)
      W_IDLE: begin
        w_done = aw_hs & w_hs;
        w_next = w_done ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
      end
      W_HAVE_AW: begin
        w_done = w_hs;
        w_next = w_hs ? W_RESP : W_HAVE_AW;
      end
      W_HAVE_W: begin
        w_done = aw_hs;
        w_next = aw_hs ? W_RESP : W_HAVE_W;
      end
      default: w_next = BREADY ? W_IDLE : W_RESP;
    endcase
  end
  always_comb begin
    r_next = r_state == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (RREADY ? R_IDLE : R_RESP);
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BRESP     <= OKAY;
      RDATA     <= '0;
      RRESP     <= OKAY;
    end else begin
      if (aw_hs) aw_addr_q <= AWADDR;
      if (w_hs) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (w_done) BRESP <= w_resp;
      if (ar_hs) begin
        RDATA <= r_data;
        RRESP <= r_resp;
      end
    end
  end
endmodule

// File: tb/tb_amba_axi4_lite_register_slave.sv
// tb_amba_axi4_lite_register_slave: directed, table-driven and random checks against a register-array model.
module tb_amba_axi4_lite_register_slave;
  import amba_axi4_pkg::*;
  localparam int N = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [2:0] awprot = 0, arprot = 0;
  responses_t bresp, rresp;
  int tests = 0, fails = 0;
  logic [31:0] mem [N];

  always #5 clk = ~clk;

  amba_axi4_lite_register_slave #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(N)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWVALID(awvalid), .AWREADY(awready), .AWADDR(awaddr), .AWPROT(awprot),
    .WVALID(wvalid), .WREADY(wready), .WDATA(wdata), .WSTRB(wstrb),
    .BVALID(bvalid), .BREADY(bready), .BRESP(bresp),
    .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr), .ARPROT(arprot),
    .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within 50 cycles", name);
  endtask

  // model: word index = addr/4; out of range when index >= N
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output responses_t r);
    r = OKAY;
`ifdef AXI4_LITE_DECERR_EN
    if (a / 4 >= N) begin
      r = DECERR;
      return;
    end
`endif
    for (int b = 0; b < 4; b++)
      if (s[b]) mem[(a / 4) % N][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output responses_t r);
    d = mem[(a / 4) % N];
    r = OKAY;
`ifdef AXI4_LITE_DECERR_EN
    if (a / 4 >= N) begin
      d = 0;
      r = DECERR;
    end
`endif
  endtask

  task automatic do_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a;
    awvalid = 1;
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!awready) timeout("aw_wait");
    @(negedge clk);
    awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1;
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wready) timeout("w_wait");
    @(negedge clk);
    wvalid = 0;
  endtask

  task automatic do_ar(input logic [31:0] a);
    int n = 0;
    araddr = a;
    arvalid = 1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) timeout("ar_wait");
    @(negedge clk);
    arvalid = 0;
  endtask

  task automatic wait_b(input int delay, output responses_t r, output int lat);
    lat = 0;
    while (!bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bvalid) timeout("b_wait");
    repeat (delay) @(negedge clk);
    r = bresp;
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int mode, input int delay, output responses_t r, output int lat);
    if (mode == 0) begin
      fork
        do_aw(a);
        do_w(d, s);
      join
    end else if (mode == 1) begin
      do_aw(a);
      do_w(d, s);
    end else begin
      do_w(d, s);
      do_aw(a);
    end
    wait_b(delay, r, lat);
  endtask

  task automatic read(input logic [31:0] a, input int delay, output logic [31:0] d,
                      output responses_t r, output int lat);
    do_ar(a);
    lat = 0;
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rvalid) timeout("r_wait");
    repeat (delay) @(negedge clk);
    d = rdata;
    r = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 0;
    #1;
    check({tag, "_rst_outputs"}, {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check({tag, "_first_cycle_ready"}, {awready, wready, arready}, 3'b000);
    @(negedge clk);
    check({tag, "_live_ready"}, {awready, wready, arready}, 3'b111);
    for (int i = 0; i < N; i++) mem[i] = 0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          mode;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    responses_t r, er;
    logic [31:0] d, ed;
    int lat;
    tbl[0] = '{32'h14, 32'hCAFEF00D, 4'hF, 0, 32'hCAFEF00D};
    tbl[1] = '{32'h14, 32'h12345678, 4'h3, 1, 32'hCAFE5678};
    tbl[2] = '{32'h14, 32'hAABBCCDD, 4'h8, 2, 32'hAAFE5678};
    tbl[3] = '{32'h18, 32'hFFFFFFFF, 4'h0, 0, 32'h00000000};
    tbl[4] = '{32'h1B, 32'h0F0F0F0F, 4'h6, 1, 32'h000F0F00};
    tbl[5] = '{32'h1C, 32'h87654321, 4'hF, 2, 32'h87654321};
    tbl[6] = '{32'h1D, 32'h00000000, 4'h1, 0, 32'h87654300};
    @(negedge clk);
    apply_reset("init");

    write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, r, lat);
    model_write(32'h4, 32'hDEADBEEF, 4'hF, er);
    check("t1_bresp", r, OKAY);
    check("t1_b_latency", lat, 0);
    read(32'h4, 0, d, r, lat);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", r, OKAY);
    check("t1_r_latency", lat, 0);

    wdata = 32'h11223344;
    wstrb = 4'h5;
    wvalid = 1;
    check("t2_ready_before_w", {awready, wready}, 2'b11);
    @(negedge clk);
    wvalid = 0;
    repeat (3) begin
      check("t2_ready_holding_w", {awready, wready}, 2'b10);
      @(negedge clk);
    end
    do_aw(32'h8);
    wait_b(0, r, lat);
    model_write(32'h8, 32'h11223344, 4'h5, er);
    check("t2_bresp", r, OKAY);
    check("t2_b_latency", lat, 0);
    read(32'h8, 0, d, r, lat);
    check("t2_rdata", d, 32'h00220044);

    fork
      do_aw(32'h10);
      do_w(32'h13572468, 4'hF);
    join
    model_write(32'h10, 32'h13572468, 4'hF, er);
    read(32'h8, 0, d, r, lat);
    check("t3_read_during_stall", d, 32'h00220044);
    check("t3_read_lat_during_stall", lat, 0);
    for (int i = 0; i < 10; i++) begin
      check("t3_stalled_b", {bvalid, bresp, awready, wready}, {1'b1, OKAY, 2'b00});
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("t3_after_b", {bvalid, awready, wready}, 3'b011);

    write(32'hC, 32'h1, 4'hF, 0, 0, r, lat);
    model_write(32'hC, 32'h1, 4'hF, er);
    awaddr = 32'hC;
    wdata = 32'hA5A5A5A5;
    wstrb = 4'hF;
    araddr = 32'hC;
    awvalid = 1;
    wvalid = 1;
    arvalid = 1;
    check("t4_all_ready", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    {awvalid, wvalid, arvalid} = 3'b000;
    check("t4_both_valid", {bvalid, rvalid}, 2'b11);
    check("t4_old_value", rdata, 32'h1);
    model_write(32'hC, 32'hA5A5A5A5, 4'hF, er);
    {bready, rready} = 2'b11;
    @(negedge clk);
    {bready, rready} = 2'b00;
    read(32'hC, 0, d, r, lat);
    check("t4_new_value", d, 32'hA5A5A5A5);

    write(32'h40, 32'h5555AAAA, 4'hF, 0, 0, r, lat);
    model_write(32'h40, 32'h5555AAAA, 4'hF, er);
    check("t5_bresp_0x40", r, er);
    read(32'h0, 0, d, r, lat);
    model_read(32'h0, ed, er);
    check("t5_reg0", d, ed);
    read(32'h40, 0, d, r, lat);
    model_read(32'h40, ed, er);
    check("t5_rdata_0x40", d, ed);
    check("t5_rresp_0x40", r, er);

    foreach (tbl[i]) begin
      write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].mode, 0, r, lat);
      model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, er);
      check("tbl_bresp", r, OKAY);
      read(tbl[i].addr, 0, d, r, lat);
      check("tbl_rdata", d, tbl[i].exp);
    end

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 32'h5F);
      if ($urandom_range(0, 2) != 0) begin
        logic [31:0] wd;
        logic [3:0] ws;
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        write(a, wd, ws, $urandom_range(0, 2), $urandom_range(0, 3), r, lat);
        model_write(a, wd, ws, er);
        check("rnd_bresp", r, er);
        check("rnd_b_latency", lat, 0);
      end else begin
        read(a, $urandom_range(0, 3), d, r, lat);
        model_read(a, ed, er);
        check("rnd_rdata", d, ed);
        check("rnd_rresp", r, er);
        check("rnd_r_latency", lat, 0);
      end
    end

    do_ar(32'h4);
    check("t6_rvalid_before_reset", rvalid, 1'b1);
    apply_reset("mid");
    for (int i = 0; i < N; i++) begin
      read(32'(i * 4), 0, d, r, lat);
      check("t6_cleared", d, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
